// File: rtl/piso_tx_with_ce.sv
// piso_tx_with_ce: parallel-in / serial-out transmitter. A word accepted in
// IDLE is shifted out MSB first, one bit per DIV clocks, with a one-cycle
// ce strobe in the last cycle of every bit slot so a CE flip-flop chain on
// the receiver captures D. A single DONE cycle follows the last bit.
//
// Handshake: a word is taken on a rising edge where valid=1, ready=1 and
// clear=0. ready is high only in IDLE. valid while ready=0 is dropped, not
// queued, and data is sampled only on the accepting edge.
//
// Every output is decoded from registered state only, so there is no
// combinational path from valid, data or clear to any output.
module piso_tx_with_ce #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             D,
  output logic             ce,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Divider needs at least one bit even when DIV=1 (it then stays at 0).
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [CW-1:0] BIT_FIRST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic             slot_end;

  // Last cycle of a bit slot: the ce cycle.
  assign slot_end = (div_cnt == DIV_LAST);

  // Main FSM with shift register, bit counter and clock divider.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (clear) begin
      // Abort: drop the in-flight word, no DONE cycle.
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid) begin
            shreg   <= data;
            bit_cnt <= BIT_FIRST;
            div_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (slot_end) begin
            div_cnt <= '0;
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            if (bit_cnt == '0) begin
              state <= ST_DONE;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    ready     = (state == ST_IDLE);
    busy      = (state == ST_SHIFT);
    done      = (state == ST_DONE);
    D         = (state == ST_SHIFT) ? shreg[WIDTH-1] : 1'b0;
    ce        = (state == ST_SHIFT) && slot_end;
    state_dbg = state;
  end

endmodule
